// File: rtl/bsg_round_robin_dispatch.sv
// bsg_round_robin_dispatch: 2-entry buffered one-to-many dispatcher with rotating sink priority.
// Define BSG_RR_DISPATCH_STRICT_EN for strict rotation (head waits for sink ptr, no skipping).
module bsg_round_robin_dispatch #(
    parameter int width_p      = 2,
    parameter int data_width_p = 8,
    localparam int ptr_w_lp    = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic [data_width_p-1:0] data_i,
    output logic                    ready_o,
    output logic [width_p-1:0]      v_o,
    output logic [data_width_p-1:0] data_o,
    input  logic [width_p-1:0]      ready_i,
    output logic [ptr_w_lp-1:0]     ptr_o
);
    logic [data_width_p-1:0] r_mem [2];
    logic                    r_rd, r_wr;
    logic [1:0]              r_cnt;
    logic [ptr_w_lp-1:0]     r_ptr, w_sel, w_ptr_nxt;
    logic                    w_any, w_enq, w_deq, w_nonempty;

    assign ready_o    = reset_n_i & (r_cnt != 2'd2);
    assign w_nonempty = reset_n_i & (r_cnt != 2'd0);
    assign w_enq      = v_i & ready_o;

`ifdef BSG_RR_DISPATCH_STRICT_EN
    assign w_sel = r_ptr;
    assign w_any = 1'b1;
`else
    // Scan from the far end so the last hit is the first ready sink at or after ptr.
    always_comb begin
        w_sel = r_ptr;
        w_any = 1'b0;
        for (int i = width_p - 1; i >= 0; i--) begin
            int k;
            k = int'(r_ptr) + i;
            k = (k >= width_p) ? k - width_p : k;
            if (ready_i[k]) begin
                w_sel = ptr_w_lp'(k);
                w_any = 1'b1;
            end
        end
    end
`endif

    assign v_o       = (w_nonempty & w_any) ? (width_p'(1) << w_sel) : '0;
    assign w_deq     = |(v_o & ready_i);
    assign w_ptr_nxt = (int'(w_sel) == width_p - 1) ? '0 : w_sel + 1'b1;
    assign data_o    = r_mem[r_rd];
    assign ptr_o     = r_ptr;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_cnt <= 2'd0;
            r_ptr <= '0;
        end else begin
            r_wr  <= w_enq ? ~r_wr : r_wr;
            r_rd  <= w_deq ? ~r_rd : r_rd;
            r_ptr <= w_deq ? w_ptr_nxt : r_ptr;
            r_cnt <= r_cnt + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_wr] <= data_i;
    end

`ifndef SYNTHESIS
    a_onehot:   assert property (@(posedge clk_i) $onehot0(v_o));
    a_no_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(w_deq && r_cnt == 2'd0));
    a_v_known:  assert property (@(posedge clk_i) reset_n_i |-> !$isunknown(v_i));
`endif
endmodule
